// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers BCD digits from multiplexed active-low anode/cathode lines.
// Optional stale-digit timeout enabled by defining SEG7_SCAN_READER_STALE_TIMEOUT_EN.
module seg7_scan_reader #(
    parameter int DIGITS  = 4,
    parameter int SETTLE  = 4,
    parameter int MATCH   = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     an_n,
    input  logic [6:0]            seg_n,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     err,
    output logic                  frame_done
);
    localparam int KW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam int MW = $clog2(MATCH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_HOLD} state_t;

    state_t state, state_n;
    logic [KW-1:0] k, k_n, an_k, cmt_k;
    logic [SW-1:0] cnt, cnt_n;
    logic [MW-1:0] mcnt, mcnt_n;
    logic [6:0] ref_seg, ref_n, cmt_pat;
    logic an_ok, commit, cmt, dec_ok, is_blank;
    logic [3:0] nz, dec_val;
    logic [DIGITS-1:0] mask, mask_set;

    always_comb begin
        nz = '0;
        an_k = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_n[i]) begin
                nz = nz + 4'd1;
                an_k = KW'(i);
            end
        end
        an_ok = nz == 4'd1;
    end

    always_comb begin
        state_n = state;
        k_n = k;
        cnt_n = cnt;
        ref_n = ref_seg;
        mcnt_n = mcnt;
        commit = 1'b0;
        if (state == S_IDLE) begin
            if (an_ok) begin
                k_n = an_k;
                cnt_n = '0;
                state_n = S_SETTLE;
            end
        end else if (!an_ok) begin
            state_n = S_IDLE;
        end else if (an_k != k) begin
            k_n = an_k;
            cnt_n = '0;
            state_n = S_SETTLE;
        end else begin
            case (state)
                S_SETTLE: begin
                    if (cnt == SW'(SETTLE - 1)) begin
                        ref_n = seg_n;
                        mcnt_n = MW'(1);
                        commit = MATCH == 1;
                        state_n = MATCH == 1 ? S_HOLD : S_SAMPLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (seg_n == ref_seg) begin
                        mcnt_n = mcnt + 1'b1;
                        commit = mcnt_n == MW'(MATCH);
                        state_n = commit ? S_HOLD : S_SAMPLE;
                    end else begin
                        ref_n = seg_n;
                        mcnt_n = MW'(1);
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            k <= '0;
            cnt <= '0;
            mcnt <= '0;
            ref_seg <= '0;
            cmt <= 1'b0;
            cmt_k <= '0;
            cmt_pat <= '0;
        end else begin
            state <= state_n;
            k <= k_n;
            cnt <= cnt_n;
            mcnt <= mcnt_n;
            ref_seg <= ref_n;
            cmt <= commit;
            cmt_k <= k;
            cmt_pat <= seg_n;
        end
    end

    always_comb begin
        dec_ok = 1'b1;
        dec_val = 4'd0;
        is_blank = cmt_pat == 7'b1111111;
        mask_set = mask | (DIGITS'(1) << cmt_k);
        case (cmt_pat)
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0011000: dec_val = 4'd9;
            default:    dec_ok = 1'b0;
        endcase
    end

`ifdef SEG7_SCAN_READER_STALE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] age [DIGITS];
`endif

    // Stale clearing is evaluated before the commit so a same-edge commit wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits <= '0;
            digit_valid <= '0;
            blank <= '0;
            err <= '0;
            mask <= '0;
            frame_done <= 1'b0;
`ifdef SEG7_SCAN_READER_STALE_TIMEOUT_EN
            for (int i = 0; i < DIGITS; i++) age[i] <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
`ifdef SEG7_SCAN_READER_STALE_TIMEOUT_EN
                if (cmt && cmt_k == KW'(i)) begin
                    age[i] <= '0;
                end else if (age[i] != TW'(TIMEOUT)) begin
                    age[i] <= age[i] + 1'b1;
                    if (age[i] == TW'(TIMEOUT - 1)) begin
                        digit_valid[i] <= 1'b0;
                        blank[i] <= 1'b0;
                        err[i] <= 1'b0;
                    end
                end
`endif
                if (cmt && cmt_k == KW'(i)) begin
                    if (dec_ok) digits[4*i +: 4] <= dec_val;
                    digit_valid[i] <= dec_ok;
                    blank[i] <= is_blank;
                    err[i] <= !dec_ok && !is_blank;
                end
            end
            if (cmt) begin
                mask <= &mask_set ? '0 : mask_set;
                frame_done <= &mask_set;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed and random checks against a run-length reference model.
module tb_seg7_scan_reader;
    localparam int D  = 4;
    localparam int ST = 4;
    localparam int MT = 2;
    localparam int TO = 100;
    localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [D-1:0] an_n = '1;
    logic [6:0] seg_n = '1;
    logic [4*D-1:0] digits;
    logic [D-1:0] digit_valid, blank, err;
    logic frame_done;

    seg7_scan_reader #(.DIGITS(D), .SETTLE(ST), .MATCH(MT), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .an_n(an_n), .seg_n(seg_n), .digits(digits),
        .digit_valid(digit_valid), .blank(blank), .err(err), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, fd_count = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a slot commits once it has been selected for ST+MT edges and the
    // last MT samples in the post-settle window are identical; outputs follow an edge later.
    logic [D-1:0] m_prev_an;
    logic [6:0] m_prev_seg, m_pp;
    int m_sel, m_run, m_pk, m_t;
    bit m_done, m_pend;
    int m_last [D];
    logic [4*D-1:0] e_dig;
    logic [D-1:0] e_val, e_blank, e_err, m_mask;
    logic e_fd;

    function automatic int decode(input logic [6:0] p);
        if (p == 7'b1111111) return 10;
        for (int i = 0; i < 10; i++) if (PAT[i] == p) return i;
        return 11;
    endfunction

    task automatic model_edge();
        int zeros, kk, v;
        m_t++;
        if (rst) begin
            m_sel = 0; m_run = 0; m_done = 0; m_pend = 0;
            e_dig = '0; e_val = '0; e_blank = '0; e_err = '0; e_fd = 0; m_mask = '0;
            for (int i = 0; i < D; i++) m_last[i] = m_t;
            return;
        end
        e_fd = 0;
`ifdef SEG7_SCAN_READER_STALE_TIMEOUT_EN
        for (int i = 0; i < D; i++)
            if (m_t - m_last[i] == TO && !(m_pend && m_pk == i)) begin
                e_val[i] = 0; e_blank[i] = 0; e_err[i] = 0;
            end
`endif
        if (m_pend) begin
            v = decode(m_pp);
            if (v < 10) e_dig[4*m_pk +: 4] = v[3:0];
            e_val[m_pk] = v < 10;
            e_blank[m_pk] = v == 10;
            e_err[m_pk] = v == 11;
            m_last[m_pk] = m_t;
            m_mask[m_pk] = 1'b1;
            if (&m_mask) begin
                e_fd = 1;
                m_mask = '0;
            end
            m_pend = 0;
        end
        zeros = 0; kk = 0;
        for (int i = 0; i < D; i++) if (!an_n[i]) begin zeros++; kk = i; end
        if (zeros != 1) m_sel = 0;
        else if (m_sel > 0 && an_n == m_prev_an) m_sel++;
        else begin m_sel = 1; m_done = 0; end
        if (m_sel >= ST + 1) begin
            m_run = (m_sel > ST + 1 && seg_n == m_prev_seg) ? m_run + 1 : 1;
            if (!m_done && m_run >= MT) begin
                m_pend = 1; m_pk = kk; m_pp = seg_n; m_done = 1;
            end
        end
        m_prev_an = an_n;
        m_prev_seg = seg_n;
    endtask

    task automatic cyc(input logic [D-1:0] a, input logic [6:0] s);
        an_n = a;
        seg_n = s;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (frame_done) fd_count++;
        chk("digits", digits, e_dig);
        chk("digit_valid", digit_valid, e_val);
        chk("blank", blank, e_blank);
        chk("err", err, e_err);
        chk("frame_done", frame_done, e_fd);
    endtask

    task automatic slot(input int k, input logic [6:0] p, input int n);
        for (int c = 0; c < n; c++) cyc(~(D'(1) << k), p);
    endtask

    initial begin
        int n0;
        m_t = 0;
        rst = 1;
        for (int c = 0; c < 3; c++) cyc(4'b1110, 7'b0110000);
        chk("rst_digits", digits, 0);
        chk("rst_flags", {digit_valid, blank, err, frame_done}, 0);
        rst = 0;
        for (int c = 0; c < 6; c++) cyc(4'b1110, 7'b0110000);
        chk("lat_before", digit_valid[0], 0);
        cyc(4'b1110, 7'b0110000);
        chk("lat_digit", digits[3:0], 3);
        chk("lat_valid", digit_valid[0], 1);

        for (int f = 0; f < 2; f++) begin
            n0 = fd_count;
            slot(0, PAT[4], 20); slot(1, PAT[2], 20); slot(2, PAT[0], 20); slot(3, PAT[2], 20);
            chk("frame_pulses", fd_count - n0, 1);
        end
        chk("frame_digits", digits, 16'h2024);
        chk("frame_valid", digit_valid, 4'b1111);

        slot(0, PAT[4], 20); slot(1, 7'b1111111, 20); slot(2, 7'b1010101, 20); slot(3, PAT[2], 20);
        chk("be_blank", blank, 4'b0010);
        chk("be_err", err, 4'b0100);
        chk("be_valid", digit_valid, 4'b1001);
        chk("be_digits", digits, 16'h2024);

        for (int i = 0; i < 10; i++) cyc(4'b1110, (i % 2 == 0) ? 7'b0011000 : 7'b0000000);
        chk("tog_none", digits[3:0], 4);
        cyc(4'b1110, 7'b0011000);
        cyc(4'b1110, 7'b0011000);
        chk("tog_wait", digits[3:0], 4);
        cyc(4'b1110, 7'b0011000);
        chk("tog_commit", digits[3:0], 9);

        n0 = fd_count;
        slot(1, PAT[7], 3); slot(2, PAT[7], 3);
        for (int c = 0; c < 8; c++) cyc(4'b1100, PAT[7]);
        for (int c = 0; c < 4; c++) cyc(4'b1111, PAT[7]);
        chk("short_fd", fd_count - n0, 0);
        chk("short_digits", digits, 16'h2029);
        chk("short_valid", digit_valid, 4'b1001);

        slot(0, PAT[5], 10);
        for (int c = 0; c < 150; c++) cyc(4'b1111, PAT[5]);
        chk("stale_digit", digits[3:0], 5);
`ifdef SEG7_SCAN_READER_STALE_TIMEOUT_EN
        chk("stale_valid", digit_valid[0], 0);
`else
        chk("stale_valid", digit_valid[0], 1);
`endif

        for (int s = 0; s < 300; s++) begin
            automatic int r = $urandom_range(0, 99);
            automatic int r2 = $urandom_range(0, 99);
            automatic int n = $urandom_range(1, 12);
            automatic logic [D-1:0] a = (r < 85) ? ~(D'(1) << $urandom_range(0, D - 1)) : D'($urandom);
            automatic logic [6:0] p = (r2 < 80) ? PAT[$urandom_range(0, 9)] :
                                      (r2 < 90) ? 7'b1111111 : 7'($urandom);
            for (int c = 0; c < n; c++) begin
                rst = $urandom_range(0, 299) == 0;
                cyc(a, ($urandom_range(0, 9) == 0) ? 7'($urandom) : p);
            end
        end
        rst = 0;
        cyc(4'b1111, 7'b1111111);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
